// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Sequencer that drives a CORDIC Sine_wave generator through one complete sweep:
// the amplitude fades in, the phase increment steps from f_start to f_stop with a
// programmable dwell per step, and then the amplitude fades out. A sweep can be
// aborted at any point. The abort always passes through the fade-out, so the
// output never jumps.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, launches a sweep when idle
//   abort        one-cycle pulse, forces an early fade-out
//   f_start      first step value (unsigned)
//   f_stop       final step value (unsigned, may be below f_start)
//   f_inc        step increment magnitude per dwell period
//   dwell        cycles each step value is held (0 behaves as 1)
//   ampl_target  plateau amplitude (clamped to the largest positive signed value)
//   ampl_inc     amplitude change per cycle during fades (0 means an immediate jump)
//   nco_ce       to Sine_wave ce
//   step_out     to Sine_wave step
//   ampl_out     to Sine_wave ampl
//   busy         high while a sweep is in progress
//   done         one-cycle pulse when a sweep ends
module nco_sweep_ctrl #(
   parameter int DATA_WIDTH  = 12,
   parameter int ANGLE_WIDTH = 16,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ANGLE_WIDTH-1:0] f_start,
   input  logic [ANGLE_WIDTH-1:0] f_stop,
   input  logic [ANGLE_WIDTH-1:0] f_inc,
   input  logic [DWELL_WIDTH-1:0] dwell,
   input  logic [DATA_WIDTH-1:0]  ampl_target,
   input  logic [DATA_WIDTH-1:0]  ampl_inc,
   output logic                   nco_ce,
   output logic [ANGLE_WIDTH-1:0] step_out,
   output logic [DATA_WIDTH-1:0]  ampl_out,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] FADE_IN  = 2'd1;
   localparam logic [1:0] SWEEP    = 2'd2;
   localparam logic [1:0] FADE_OUT = 2'd3;

   // Largest positive value of a signed DATA_WIDTH amplitude.
   localparam logic [DATA_WIDTH-1:0] AMPL_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   logic [1:0]             state;
   logic [ANGLE_WIDTH-1:0] f_stop_l;
   logic [ANGLE_WIDTH-1:0] f_inc_l;
   logic [DWELL_WIDTH-1:0] dwell_m1_l;
   logic [DATA_WIDTH-1:0]  target_l;
   logic [DATA_WIDTH-1:0]  ampl_inc_l;
   logic                   dir_up_l;
   logic [DWELL_WIDTH-1:0] dwell_cnt;

   logic [DATA_WIDTH:0]    ampl_sum;
   logic [DATA_WIDTH-1:0]  ampl_rise;
   logic [DATA_WIDTH-1:0]  ampl_fall;
   logic [ANGLE_WIDTH-1:0] step_next;

   // Fade arithmetic. The rising sum carries one extra bit so that it cannot wrap
   // before it is compared with the target. The falling path checks for underflow
   // before it subtracts. An increment of zero gives a jump in a single cycle.
   always_comb begin
      ampl_sum  = {1'b0, ampl_out} + {1'b0, ampl_inc_l};
      ampl_rise = ampl_sum[DATA_WIDTH-1:0];
      if (ampl_inc_l == '0 || ampl_sum >= {1'b0, target_l}) begin
         ampl_rise = target_l;
      end
      ampl_fall = ampl_out - ampl_inc_l;
      if (ampl_inc_l == '0 || ampl_out <= ampl_inc_l) begin
         ampl_fall = '0;
      end
   end

   // Next step value toward f_stop. The remaining distance is compared with the
   // increment before the add or subtract happens. This stops the step from
   // overshooting f_stop and from wrapping. A zero increment goes straight to f_stop.
   always_comb begin
      step_next = f_stop_l;
      if (f_inc_l != '0) begin
         if (dir_up_l) begin
            if (f_stop_l - step_out > f_inc_l) begin
               step_next = step_out + f_inc_l;
            end
         end else begin
            if (step_out - f_stop_l > f_inc_l) begin
               step_next = step_out - f_inc_l;
            end
         end
      end
   end

   // Main sequencer. The configuration is captured and normalised when start is
   // accepted, so software can rewrite its registers during a sweep. In FADE_IN and
   // SWEEP, abort takes priority over normal progress. On that edge the amplitude is
   // held, and the fade-out then starts from the current level.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         nco_ce     <= 1'b0;
         step_out   <= '0;
         ampl_out   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dwell_cnt  <= '0;
         f_stop_l   <= '0;
         f_inc_l    <= '0;
         dwell_m1_l <= '0;
         target_l   <= '0;
         ampl_inc_l <= '0;
         dir_up_l   <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  f_stop_l   <= f_stop;
                  f_inc_l    <= f_inc;
                  dwell_m1_l <= (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
                  target_l   <= (ampl_target > AMPL_MAX) ? AMPL_MAX : ampl_target;
                  ampl_inc_l <= ampl_inc;
                  dir_up_l   <= (f_stop >= f_start);
                  step_out   <= f_start;
                  ampl_out   <= '0;
                  nco_ce     <= 1'b1;
                  busy       <= 1'b1;
                  state      <= FADE_IN;
               end
            end
            FADE_IN: begin
               if (abort) begin
                  state <= FADE_OUT;
               end else begin
                  ampl_out <= ampl_rise;
                  if (ampl_rise == target_l) begin
                     dwell_cnt <= dwell_m1_l;
                     state     <= SWEEP;
                  end
               end
            end
            SWEEP: begin
               if (abort) begin
                  state <= FADE_OUT;
               end else if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
               end else if (step_out == f_stop_l) begin
                  state <= FADE_OUT;
               end else begin
                  step_out  <= step_next;
                  dwell_cnt <= dwell_m1_l;
               end
            end
            default: begin
               ampl_out <= ampl_fall;
               if (ampl_fall == '0) begin
                  step_out <= '0;
                  nco_ce   <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed testbench for nco_sweep_ctrl. Each sweep scenario drives a
// configuration, pulses start and then compares every output cycle by cycle
// against hand-computed values.
module tb_nco_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [15:0] f_start;
   logic [15:0] f_stop;
   logic [15:0] f_inc;
   logic [15:0] dwell;
   logic [11:0] ampl_target;
   logic [11:0] ampl_inc;
   logic        nco_ce;
   logic [15:0] step_out;
   logic [11:0] ampl_out;
   logic        busy;
   logic        done;

   int vectors = 0;
   int misses  = 0;

   nco_sweep_ctrl #(
      .DATA_WIDTH(12),
      .ANGLE_WIDTH(16),
      .DWELL_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .f_start(f_start),
      .f_stop(f_stop),
      .f_inc(f_inc),
      .dwell(dwell),
      .ampl_target(ampl_target),
      .ampl_inc(ampl_inc),
      .nco_ce(nco_ce),
      .step_out(step_out),
      .ampl_out(ampl_out),
      .busy(busy),
      .done(done)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         misses++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock: release pulses just after the edge, then compare all outputs at the falling edge
   task automatic expectCycle(input string tag, input logic eCe, input int eStep,
                              input int eAmpl, input logic eBusy, input logic eDone);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".ce"},   int'(nco_ce),   int'(eCe));
      checkOutput({tag, ".step"}, int'(step_out), eStep);
      checkOutput({tag, ".ampl"}, int'(ampl_out), eAmpl);
      checkOutput({tag, ".busy"}, int'(busy),     int'(eBusy));
      checkOutput({tag, ".done"}, int'(done),     int'(eDone));
   endtask

   // Load a configuration and raise start for the next clock edge (called at a falling edge)
   task automatic applyStimulus(input int fs, input int fe, input int fi, input int dw,
                                input int tgt, input int ainc);
      f_start     = 16'(fs);
      f_stop      = 16'(fe);
      f_inc       = 16'(fi);
      dwell       = 16'(dw);
      ampl_target = 12'(tgt);
      ampl_inc    = 12'(ainc);
      start       = 1'b1;
   endtask

   // Apply reset across one edge, then expect the idle state for two cycles with no done pulse
   task automatic applyReset(input string tag);
      reset = 1'b1;
      expectCycle({tag, ".rst"}, 1'b0, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;
      expectCycle({tag, ".post"}, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   // Nominal up-sweep. The inputs are scrambled after start to show that the configuration was latched.
   task automatic runNominal(input string tag);
      applyStimulus(500, 520, 10, 3, 800, 200);
      expectCycle({tag, ".acc"}, 1'b1, 500, 0, 1'b1, 1'b0);
      f_start = 16'd7; f_stop = 16'd9999; f_inc = 16'd1; dwell = 16'd50;
      ampl_target = 12'd5; ampl_inc = 12'd1;
      for (int i = 1; i <= 3; i++) expectCycle({tag, ".fin"}, 1'b1, 500, 200 * i, 1'b1, 1'b0);
      for (int s = 0; s < 3; s++)
         for (int d = 0; d < 3; d++)
            expectCycle({tag, ".swp"}, 1'b1, 500 + 10 * s, 800, 1'b1, 1'b0);
      expectCycle({tag, ".fo0"}, 1'b1, 520, 800, 1'b1, 1'b0);
      for (int i = 3; i >= 1; i--) expectCycle({tag, ".fout"}, 1'b1, 520, 200 * i, 1'b1, 1'b0);
      expectCycle({tag, ".done"}, 1'b0, 0, 0, 1'b0, 1'b1);
      expectCycle({tag, ".idle"}, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      f_start = '0; f_stop = '0; f_inc = '0; dwell = '0; ampl_target = '0; ampl_inc = '0;
      @(negedge clk);
      expectCycle("reset", 1'b0, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;
      expectCycle("idle", 1'b0, 0, 0, 1'b0, 1'b0);

      runNominal("nom");

      // Down-sweep: the last step clamps to 497 instead of going to 490
      applyStimulus(520, 497, 10, 1, 100, 100);
      expectCycle("dn.acc", 1'b1, 520, 0, 1'b1, 1'b0);
      expectCycle("dn.s0", 1'b1, 520, 100, 1'b1, 1'b0);
      expectCycle("dn.s1", 1'b1, 510, 100, 1'b1, 1'b0);
      expectCycle("dn.s2", 1'b1, 500, 100, 1'b1, 1'b0);
      expectCycle("dn.s3", 1'b1, 497, 100, 1'b1, 1'b0);
      expectCycle("dn.fo", 1'b1, 497, 100, 1'b1, 1'b0);
      expectCycle("dn.done", 1'b0, 0, 0, 1'b0, 1'b1);

      // Abort in SWEEP at step 510. A start during the fade must be ignored.
      applyStimulus(500, 520, 10, 3, 800, 300);
      expectCycle("ab.acc", 1'b1, 500, 0, 1'b1, 1'b0);
      expectCycle("ab.f1", 1'b1, 500, 300, 1'b1, 1'b0);
      expectCycle("ab.f2", 1'b1, 500, 600, 1'b1, 1'b0);
      expectCycle("ab.s0", 1'b1, 500, 800, 1'b1, 1'b0);
      expectCycle("ab.s1", 1'b1, 500, 800, 1'b1, 1'b0);
      expectCycle("ab.s2", 1'b1, 500, 800, 1'b1, 1'b0);
      expectCycle("ab.s3", 1'b1, 510, 800, 1'b1, 1'b0);
      abort = 1'b1;
      expectCycle("ab.fo", 1'b1, 510, 800, 1'b1, 1'b0);
      start = 1'b1;
      expectCycle("ab.o1", 1'b1, 510, 500, 1'b1, 1'b0);
      expectCycle("ab.o2", 1'b1, 510, 200, 1'b1, 1'b0);
      expectCycle("ab.done", 1'b0, 0, 0, 1'b0, 1'b1);
      expectCycle("ab.idle", 1'b0, 0, 0, 1'b0, 1'b0);

      // Degenerate configuration, with abort asserted together with start in IDLE
      applyStimulus(100, 900, 0, 0, 1000, 0);
      abort = 1'b1;
      expectCycle("dg.acc", 1'b1, 100, 0, 1'b1, 1'b0);
      expectCycle("dg.s0", 1'b1, 100, 1000, 1'b1, 1'b0);
      expectCycle("dg.s1", 1'b1, 900, 1000, 1'b1, 1'b0);
      expectCycle("dg.fo", 1'b1, 900, 1000, 1'b1, 1'b0);
      expectCycle("dg.done", 1'b0, 0, 0, 1'b0, 1'b1);

      // Amplitude clamp to 2047, with f_start == f_stop giving one dwell of 2 cycles
      applyStimulus(50, 50, 5, 2, 4095, 1000);
      expectCycle("cl.acc", 1'b1, 50, 0, 1'b1, 1'b0);
      expectCycle("cl.f1", 1'b1, 50, 1000, 1'b1, 1'b0);
      expectCycle("cl.f2", 1'b1, 50, 2000, 1'b1, 1'b0);
      expectCycle("cl.s0", 1'b1, 50, 2047, 1'b1, 1'b0);
      expectCycle("cl.s1", 1'b1, 50, 2047, 1'b1, 1'b0);
      expectCycle("cl.fo", 1'b1, 50, 2047, 1'b1, 1'b0);
      expectCycle("cl.o1", 1'b1, 50, 1047, 1'b1, 1'b0);
      expectCycle("cl.o2", 1'b1, 50, 47, 1'b1, 1'b0);
      expectCycle("cl.done", 1'b0, 0, 0, 1'b0, 1'b1);

      // Reset during FADE_IN
      applyStimulus(500, 520, 10, 3, 800, 200);
      expectCycle("rf.acc", 1'b1, 500, 0, 1'b1, 1'b0);
      expectCycle("rf.f1", 1'b1, 500, 200, 1'b1, 1'b0);
      applyReset("rf");

      // Reset during SWEEP, followed by a fresh nominal sweep
      applyStimulus(500, 520, 10, 3, 800, 200);
      expectCycle("rs.acc", 1'b1, 500, 0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) expectCycle("rs.fin", 1'b1, 500, 200 * i, 1'b1, 1'b0);
      expectCycle("rs.s1", 1'b1, 500, 800, 1'b1, 1'b0);
      expectCycle("rs.s2", 1'b1, 500, 800, 1'b1, 1'b0);
      expectCycle("rs.s3", 1'b1, 510, 800, 1'b1, 1'b0);
      applyReset("rs");
      runNominal("re");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer for the CORDIC sine/cosine generator (Sine_wave). It drives the generator's ce, step (phase increment) and ampl inputs to run a complete frequency sweep:
- amplitude fade-in;
- stepped frequency ramp from f_start to f_stop with a programmable dwell per step;
- amplitude fade-out.

It sits between the register/config interface and the Sine_wave instance, and it lets software launch and abort sweeps without glitching the output.

Parameters:
DATA_WIDTH, 12, width of ampl bus (matches Sine_wave DATA_WIDTH)
ANGLE_WIDTH, 16, width of step/frequency buses (matches Sine_wave ANGLE_WIDTH)
DWELL_WIDTH, 16, width of dwell counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; launches sweep when idle
abort  in  1  one-cycle pulse; forces early fade-out
f_start  in  ANGLE_WIDTH  first step value (unsigned)
f_stop  in  ANGLE_WIDTH  final step value (unsigned; may be below f_start)
f_inc  in  ANGLE_WIDTH  step increment magnitude per dwell period
dwell  in  DWELL_WIDTH  cycles each step value is held
ampl_target  in  DATA_WIDTH  plateau amplitude (unsigned)
ampl_inc  in  DATA_WIDTH  amplitude change per cycle during fades
nco_ce  out  1  to Sine_wave ce
step_out  out  ANGLE_WIDTH  to Sine_wave step
ampl_out  out  DATA_WIDTH  to Sine_wave ampl
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the sweep ends

Behaviour:
- Reset state:
  - States: IDLE, FADE_IN, SWEEP, FADE_OUT.
  - Reset forces IDLE next edge from any state, including mid-sweep.
  - Output values in IDLE and after reset: nco_ce=0, step_out=0, ampl_out=0, busy=0, done=0.
- Start (IDLE only):
  - All config inputs are latched on the accepting edge; later changes have no effect until the next start.
  - start is ignored while busy.
- Latched-config normalisation:
  - ampl_target is clamped to 2^(DATA_WIDTH-1)-1.
  - ampl_inc=0 means one-cycle jump to target (fade-in) or to 0 (fade-out).
  - dwell=0 is treated as 1.
  - f_inc=0 means a direct jump to f_stop after the first dwell.
  - Sweep direction is up if f_stop>=f_start, otherwise down.
- IDLE->FADE_IN (the edge that accepts start):
  - step_out=f_start, ampl_out=0, nco_ce=1, busy=1.
- FADE_IN:
  - Each cycle ampl_out <= min(ampl_out+ampl_inc, target), computed with one extra bit so there is no wrap.
  - Goes to SWEEP on the edge where ampl_out becomes target.
  - The dwell counter loads dwell-1 on that same edge.
- SWEEP:
  - Each step value is held for exactly dwell cycles in SWEEP.
  - When the counter reaches 0:
    - if step_out==f_stop, go to FADE_OUT;
    - otherwise step_out moves toward f_stop by f_inc, clamped to f_stop (never overshoots, never wraps), and the counter reloads.
  - f_start==f_stop gives a single dwell period.
- FADE_OUT:
  - Each cycle ampl_out <= max(ampl_out-ampl_inc, 0), computed without underflow.
  - On the edge where ampl_out becomes 0, go to IDLE: step_out=0, nco_ce=0, busy=0, done=1 for exactly one cycle.
  - step_out holds its last value throughout FADE_OUT.
- abort:
  - In FADE_IN or SWEEP: next edge enters FADE_OUT, fading from the current ampl_out.
  - In FADE_OUT or IDLE: ignored.
- Simultaneous events:
  - start and abort together in IDLE: start accepted, abort ignored.
  - reset has priority over everything.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Nominal up-sweep: f_start=500, f_stop=520, f_inc=10, dwell=3, ampl_target=800, ampl_inc=200; start pulse.
  - ampl_out sequence 0,200,400,600,800.
  - step_out 500x3, 510x3, 520x3 cycles in SWEEP.
  - ampl_out 600,400,200,0.
  - Single done pulse; busy low, nco_ce=0 and step_out=0 the same cycle.
- Down-sweep with clamp: f_start=520, f_stop=497, f_inc=10, dwell=1 -> step_out 520,510,500,497; never below 497.
- Abort mid-SWEEP while step_out=510 and ampl_out=800 (ampl_inc=300) -> next cycle FADE_OUT, ampl_out 500,200,0, then done; start during fade ignored.
- Degenerate config: dwell=0, f_inc=0, ampl_inc=0, f_start=100, f_stop=900 -> ampl_out jumps 0->target in one cycle, step_out 100 for 1 cycle then 900 for 1 cycle, ampl_out 0 in one cycle, done.
- Clamp: ampl_target=4095 with DATA_WIDTH=12 -> plateau ampl_out=2047.
- Reset mid-FADE_IN and mid-SWEEP -> all outputs 0 next cycle, no done pulse; a fresh start afterwards runs the nominal sequence correctly.
